// File: rtl/duck_ctl.sv
// Per-frame duck motion controller: flight, hit, fall and escape lifecycle.
// Optional vertical zigzag during flight is enabled by defining DUCK_ZIGZAG_EN.
module duck_ctl #(
    parameter int unsigned X_START         = 0,
    parameter int unsigned Y_START         = 600,
    parameter int unsigned V_SPEED         = 4,
    parameter int unsigned FALL_SPEED      = 8,
    parameter int unsigned HIT_HOLD_FRAMES = 30,
    parameter int unsigned ZIGZAG_FRAMES   = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        hit,
    output logic [10:0] duck_x,
    output logic [9:0]  duck_y,
    output logic        duck_dir,
    output logic [1:0]  duck_state,
    output logic        escaped,
    output logic        downed
);

    // Screen geometry mirrored from DH_pkg so this file stands alone.
    localparam int unsigned H_SPEED     = 10;
    localparam int unsigned HOR_PIXELS  = 1024;
    localparam int unsigned DUCK_WIDTH  = 64;
    localparam int unsigned VER_PIXELS  = 768;
    localparam int unsigned DUCK_HEIGHT = 48;
    localparam int unsigned X_MAX       = HOR_PIXELS - DUCK_WIDTH;
    localparam int unsigned Y_FLOOR     = VER_PIXELS - DUCK_HEIGHT;
    localparam int unsigned CNT_MAX     = (HIT_HOLD_FRAMES > ZIGZAG_FRAMES) ? HIT_HOLD_FRAMES : ZIGZAG_FRAMES;
    localparam int unsigned CW          = $clog2(CNT_MAX + 1);

    localparam logic [10:0]   X_START_C = 11'(X_START);
    localparam logic [9:0]    Y_START_C = 10'(Y_START);
    localparam logic [10:0]   H_SPEED_C = 11'(H_SPEED);
    localparam logic [9:0]    V_SPEED_C = 10'(V_SPEED);
    localparam logic [11:0]   X_MAX_C   = 12'(X_MAX);
    localparam logic [10:0]   Y_FLOOR_C = 11'(Y_FLOOR);
    localparam logic [CW-1:0] HIT_LAST  = CW'(HIT_HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FLY  = 2'b01,
        S_HIT  = 2'b10,
        S_FALL = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          dir_q, dir_d;
    logic          esc_q, esc_d;
    logic          dn_q, dn_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   x_sum;
    logic [10:0]   y_fall_sum;
    logic          esc_now;

    assign x_sum      = {1'b0, x_q} + {1'b0, H_SPEED_C};
    assign y_fall_sum = {1'b0, y_q} + 11'(FALL_SPEED);

`ifdef DUCK_ZIGZAG_EN
    localparam logic [CW-1:0] ZZ_LAST = CW'(ZIGZAG_FRAMES - 1);
    logic          vdir_q, vdir_d;
    logic [CW-1:0] zz_q, zz_d;
    logic [10:0]   y_rise_sum;

    assign y_rise_sum = {1'b0, y_q} + {1'b0, V_SPEED_C};
    assign esc_now    = !vdir_q && (y_q <= V_SPEED_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vdir_q <= 1'b0;
            zz_q   <= '0;
        end else begin
            vdir_q <= vdir_d;
            zz_q   <= zz_d;
        end
    end
`else
    assign esc_now = (y_q <= V_SPEED_C);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // A terminal frame leaves the final position and pulse visible for one
    // cycle; the return to IDLE happens on the following cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_FLY;
            S_FLY: begin
                if (esc_q)    state_d = S_IDLE;
                else if (hit) state_d = S_HIT;
            end
            S_HIT:  if (frame_tick && cnt_q == HIT_LAST) state_d = S_FALL;
            S_FALL: if (dn_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        dir_d = dir_q;
        cnt_d = cnt_q;
        esc_d = 1'b0;
        dn_d  = 1'b0;
`ifdef DUCK_ZIGZAG_EN
        vdir_d = vdir_q;
        zz_d   = zz_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                x_d   = X_START_C;
                y_d   = Y_START_C;
                dir_d = 1'b0;
`ifdef DUCK_ZIGZAG_EN
                vdir_d = 1'b0;
                zz_d   = '0;
`endif
            end
            S_FLY: begin
                if (esc_q) begin
                    x_d   = X_START_C;
                    y_d   = Y_START_C;
                    dir_d = 1'b0;
                end else if (hit) begin
                    cnt_d = '0;
                end else if (frame_tick) begin
                    if (!dir_q) begin
                        if (x_sum >= X_MAX_C) begin
                            x_d   = X_MAX_C[10:0];
                            dir_d = 1'b1;
                        end else begin
                            x_d = x_sum[10:0];
                        end
                    end else if (x_q <= H_SPEED_C) begin
                        x_d   = '0;
                        dir_d = 1'b0;
                    end else begin
                        x_d = x_q - H_SPEED_C;
                    end
`ifdef DUCK_ZIGZAG_EN
                    if (vdir_q) begin
                        if (y_rise_sum >= {1'b0, Y_START_C}) begin
                            y_d    = Y_START_C;
                            vdir_d = 1'b0;
                        end else begin
                            y_d = y_rise_sum[9:0];
                        end
                    end else if (esc_now) begin
                        esc_d = 1'b1;
                    end else begin
                        y_d = y_q - V_SPEED_C;
                    end
                    if (zz_q == ZZ_LAST) begin
                        zz_d   = '0;
                        vdir_d = ~vdir_d;
                    end else begin
                        zz_d = zz_q + 1'b1;
                    end
`else
                    if (esc_now) esc_d = 1'b1;
                    else         y_d   = y_q - V_SPEED_C;
`endif
                end
            end
            S_HIT: if (frame_tick) cnt_d = cnt_q + 1'b1;
            S_FALL: begin
                if (dn_q) begin
                    x_d   = X_START_C;
                    y_d   = Y_START_C;
                    dir_d = 1'b0;
                end else if (frame_tick) begin
                    if (y_fall_sum >= Y_FLOOR_C) begin
                        y_d  = Y_FLOOR_C[9:0];
                        dn_d = 1'b1;
                    end else begin
                        y_d = y_fall_sum[9:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= X_START_C;
            y_q   <= Y_START_C;
            dir_q <= 1'b0;
            esc_q <= 1'b0;
            dn_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            dir_q <= dir_d;
            esc_q <= esc_d;
            dn_q  <= dn_d;
            cnt_q <= cnt_d;
        end
    end

    assign duck_x     = x_q;
    assign duck_y     = y_q;
    assign duck_dir   = dir_q;
    assign duck_state = state_q;
    assign escaped    = esc_q;
    assign downed     = dn_q;

endmodule
